// File: rtl/word_window_buffer_if.sv
// Bundle of push, read-request and read-response signals for word_window_buffer.
// master drives requests (upstream/bench), slave is the window itself.
interface word_window_buffer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int IDX_WIDTH  = 5
);
  logic                            clear;
  logic [WORD_WIDTH-1:0]           word_in;
  logic                            word_valid;
  logic                            word_ready;
  logic                            hold;
  logic                            rd_req;
  logic [NUM_PORTS*IDX_WIDTH-1:0]  rd_idx;
  logic [NUM_PORTS-1:0]            rd_en;
  logic                            rd_accept;
  logic [NUM_PORTS*WORD_WIDTH-1:0] rd_data;
  logic [NUM_PORTS-1:0]            rd_hit;
  logic                            rd_valid;
  logic                            rd_ready;
  logic [IDX_WIDTH:0]              count;
  logic                            full;
  logic [31:0]                     push_total;

  modport master (
    output clear, word_in, word_valid, hold, rd_req, rd_idx, rd_en, rd_ready,
    input  word_ready, rd_accept, rd_data, rd_hit, rd_valid, count, full, push_total
  );

  modport slave (
    input  clear, word_in, word_valid, hold, rd_req, rd_idx, rd_en, rd_ready,
    output word_ready, rd_accept, rd_data, rd_hit, rd_valid, count, full, push_total
  );
endinterface

// File: rtl/word_window_buffer.sv
// Circular-buffer sliding window of the last DEPTH words with NUM_PORTS
// indexed read ports and a valid/ready-held registered read response.
module word_window_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 19,
  parameter int NUM_PORTS  = 4,
  parameter int IDX_WIDTH  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  word_window_buffer_if.slave bus
);
  localparam int CW = IDX_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WORD_WIDTH-1:0]           mem_q [DEPTH];
  logic [IDX_WIDTH-1:0]            head_q, head_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [31:0]                     push_total_q, push_total_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]            rd_hit_q, rd_hit_d;
  logic [NUM_PORTS*WORD_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                            word_ready, push, full, rd_accept;
  logic [IDX_WIDTH-1:0]            wr_slot;
  logic [NUM_PORTS-1:0]            port_hit;
  logic [NUM_PORTS*WORD_WIDTH-1:0] port_data;

  // Sum is always < 2*DEPTH, so one conditional subtract replaces a modulo.
  function automatic logic [IDX_WIDTH-1:0] slot_of(input logic [CW-1:0] s);
    return IDX_WIDTH'((s >= DEPTH_C) ? s - DEPTH_C : s);
  endfunction

  always_comb begin
    word_ready   = !bus.hold && !bus.clear;
    push         = bus.word_valid && word_ready;
    full         = (count_q == DEPTH_C);
    rd_accept    = bus.rd_req && (!rd_valid_q || bus.rd_ready) && !bus.clear;
    wr_slot      = full ? head_q : slot_of({1'b0, head_q} + count_q);
    head_d       = head_q;
    count_d      = count_q;
    push_total_d = push_total_q;
    if (bus.clear) begin
      head_d       = '0;
      count_d      = '0;
      push_total_d = '0;
    end else if (push) begin
      push_total_d = push_total_q + 32'd1;
      if (full) head_d  = slot_of({1'b0, head_q} + ONE_C);
      else      count_d = count_q + ONE_C;
    end
  end

  // Read lookups use the pre-push head/count, so a same-cycle push is invisible.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [CW-1:0]        idx;
    logic [IDX_WIDTH-1:0] slot;
    assign idx         = {1'b0, bus.rd_idx[p*IDX_WIDTH +: IDX_WIDTH]};
    assign slot        = slot_of({1'b0, head_q} + idx);
    assign port_hit[p] = bus.rd_en[p] && (idx < count_q);
    assign port_data[p*WORD_WIDTH +: WORD_WIDTH] = port_hit[p] ? mem_q[slot] : '0;
  end

  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_hit_d   = rd_hit_q;
    rd_data_d  = rd_data_q;
    if (bus.clear) begin
      rd_valid_d = 1'b0;
      rd_hit_d   = '0;
      rd_data_d  = '0;
    end else if (rd_accept) begin
      rd_valid_d = 1'b1;
      rd_hit_d   = port_hit;
      rd_data_d  = port_data;
    end else if (bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      count_q      <= '0;
      push_total_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      head_q       <= head_d;
      count_q      <= count_d;
      push_total_q <= push_total_d;
      rd_valid_q   <= rd_valid_d;
      rd_hit_q     <= rd_hit_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Word storage carries no reset; it is unreachable while count is 0.
  always_ff @(posedge clk) begin
    if (push && rst_n) mem_q[wr_slot] <= bus.word_in;
  end

  assign bus.word_ready = word_ready;
  assign bus.rd_accept  = rd_accept;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_hit     = rd_hit_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.push_total = push_total_q;
endmodule

// File: tb/tb_word_window_buffer.sv
// Bench for word_window_buffer: directed vector table, hand-written corner
// sequences and a random run, all checked against a queue-based window model.
module tb_word_window_buffer;
  localparam int WW = 32;
  localparam int D  = 19;
  localparam int NP = 4;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_window_buffer_if #(.WORD_WIDTH(WW), .NUM_PORTS(NP), .IDX_WIDTH(IW)) bus ();

  word_window_buffer #(.WORD_WIDTH(WW), .DEPTH(D), .NUM_PORTS(NP), .IDX_WIDTH(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [WW-1:0]    win[$];
  logic [31:0]      m_total;
  logic             m_valid;
  logic [NP-1:0]    m_hit;
  logic [NP*WW-1:0] m_data;

  typedef struct {
    logic             wv;
    logic [WW-1:0]    w;
    logic             hold;
    logic             clr;
    logic             req;
    logic [NP*IW-1:0] idx;
    logic [NP-1:0]    en;
    logic             rdy;
    logic [IW:0]      e_count;
    logic             e_valid;
    logic [NP-1:0]    e_hit;
    logic [NP*WW-1:0] e_data;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_total = '0;
    m_valid = 1'b0;
    m_hit   = '0;
    m_data  = '0;
  endtask

  task automatic set_idle();
    bus.clear      = 1'b0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.hold       = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_idx     = '0;
    bus.rd_en      = '0;
    bus.rd_ready   = 1'b1;
  endtask

  task automatic set_read(input logic [NP*IW-1:0] idx, input logic [NP-1:0] en);
    bus.rd_req = 1'b1;
    bus.rd_idx = idx;
    bus.rd_en  = en;
  endtask

  // Inputs are already driven; checks combinational outputs, advances the
  // model across one edge and compares all registered outputs after it.
  task automatic cycle();
    logic exp_acc, exp_wr;
    int   idx;
    #1;
    exp_wr  = !bus.hold && !bus.clear;
    exp_acc = bus.rd_req && (!m_valid || bus.rd_ready) && !bus.clear;
    check("word_ready", bus.word_ready, exp_wr);
    check("rd_accept", bus.rd_accept, exp_acc);
    if (bus.clear) begin
      model_reset();
    end else begin
      if (exp_acc) begin
        for (int p = 0; p < NP; p++) begin
          idx = int'(bus.rd_idx[p*IW +: IW]);
          if (bus.rd_en[p] && idx < win.size()) begin
            m_hit[p] = 1'b1;
            m_data[p*WW +: WW] = win[idx];
          end else begin
            m_hit[p] = 1'b0;
            m_data[p*WW +: WW] = '0;
          end
        end
        m_valid = 1'b1;
      end else if (bus.rd_ready) begin
        m_valid = 1'b0;
      end
      if (exp_wr && bus.word_valid) begin
        win.push_back(bus.word_in);
        if (win.size() > D) void'(win.pop_front());
        m_total++;
      end
    end
    @(posedge clk);
    #1;
    check("count", bus.count, win.size());
    check("full", bus.full, win.size() == D);
    check("push_total", bus.push_total, m_total);
    check("rd_valid", bus.rd_valid, m_valid);
    check("rd_hit", bus.rd_hit, m_hit);
    check("rd_data", bus.rd_data, m_data);
  endtask

  initial begin
    logic [NP*WW-1:0] held;

    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_total", bus.push_total, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_hit", bus.rd_hit, 0);
    check("rst_data", bus.rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1, 6'd1, 1'b0, 4'h0, 128'h0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1, 6'd2, 1'b0, 4'h0, 128'h0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1, 6'd3, 1'b0, 4'h0, 128'h0};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, {5'd1, 5'd3, 5'd2, 5'd0}, 4'hF, 1'b1,
               6'd3, 1'b1, 4'b1011, {32'h22, 32'h0, 32'h33, 32'h11}};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b1,
               6'd3, 1'b0, 4'b1011, {32'h22, 32'h0, 32'h33, 32'h11}};
    tbl[5] = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b0, '0, 4'h0, 1'b1,
               6'd3, 1'b0, 4'b1011, {32'h22, 32'h0, 32'h33, 32'h11}};
    tbl[6] = tbl[5];
    tbl[7] = tbl[5];
    tbl[8] = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b1, '0, 4'hF, 1'b1, 6'd0, 1'b0, 4'h0, 128'h0};
    tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 4'h1, 1'b1, 6'd0, 1'b1, 4'h0, 128'h0};

    for (int i = 0; i < 10; i++) begin
      bus.word_valid = tbl[i].wv;
      bus.word_in    = tbl[i].w;
      bus.hold       = tbl[i].hold;
      bus.clear      = tbl[i].clr;
      bus.rd_req     = tbl[i].req;
      bus.rd_idx     = tbl[i].idx;
      bus.rd_en      = tbl[i].en;
      bus.rd_ready   = tbl[i].rdy;
      cycle();
      check($sformatf("tbl%0d_count", i), bus.count, tbl[i].e_count);
      check($sformatf("tbl%0d_valid", i), bus.rd_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_hit", i), bus.rd_hit, tbl[i].e_hit);
      check($sformatf("tbl%0d_data", i), bus.rd_data, tbl[i].e_data);
    end
    check("clr_total", bus.push_total, 0);

    // Fill past DEPTH so head wraps and the oldest two words are evicted.
    set_idle();
    cycle();
    for (int i = 1; i <= 21; i++) begin
      bus.word_valid = 1'b1;
      bus.word_in    = WW'(i);
      cycle();
    end
    check("fill_count", bus.count, 19);
    check("fill_full", bus.full, 1);
    check("fill_total", bus.push_total, 21);
    set_idle();
    set_read({5'd0, 5'd0, 5'd18, 5'd0}, 4'b0011);
    cycle();
    check("wrap_idx0", bus.rd_data[31:0], 3);
    check("wrap_idx18", bus.rd_data[63:32], 21);

    set_read('0, 4'b0001);
    bus.word_valid = 1'b1;
    bus.word_in    = 32'd22;
    cycle();
    check("same_cycle_old", bus.rd_data[31:0], 3);
    check("same_cycle_total", bus.push_total, 22);
    bus.word_valid = 1'b0;
    cycle();
    check("after_push_idx0", bus.rd_data[31:0], 4);

    // Backpressure: response must stay frozen while rd_ready is low.
    set_read({5'd0, 5'd0, 5'd0, 5'd5}, 4'b0001);
    bus.rd_ready = 1'b0;
    held = bus.rd_data;
    #1;
    check("bp_accept_low", bus.rd_accept, 0);
    cycle();
    cycle();
    check("bp_data_stable", bus.rd_data, held);
    check("bp_valid_held", bus.rd_valid, 1);
    bus.rd_ready = 1'b1;
    #1;
    check("bp_accept_high", bus.rd_accept, 1);
    cycle();
    check("bp_new_data", bus.rd_data[31:0], 9);

    // Asynchronous reset in the middle of a read.
    set_idle();
    set_read('0, 4'b0001);
    cycle();
    rst_n = 1'b0;
    #2;
    check("arst_valid", bus.rd_valid, 0);
    check("arst_data", bus.rd_data, 0);
    check("arst_hit", bus.rd_hit, 0);
    check("arst_count", bus.count, 0);
    check("arst_total", bus.push_total, 0);
    model_reset();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_read('0, 4'b0001);
    cycle();
    check("post_rst_hit", bus.rd_hit, 0);
    check("post_rst_data", bus.rd_data, 0);

    for (int i = 0; i < 3000; i++) begin
      bus.clear      = ($urandom_range(0, 199) == 0);
      bus.hold       = ($urandom_range(0, 4) == 0);
      bus.word_valid = ($urandom_range(0, 3) != 0);
      bus.word_in    = $urandom;
      bus.rd_req     = $urandom_range(0, 1);
      bus.rd_idx     = NP*IW'($urandom);
      bus.rd_en      = NP'($urandom);
      bus.rd_ready   = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
